sent_msg_composer: RTL and testbench
====================================

// Module: sent_msg_composer
// PURPOSE
// - Transmit-side twin of the incoming FIX session message checker: turns a session-manager send request into an ordered tag/value beat stream for the outbound serializer.
// - Covers logon, heartbeat, logout, resend request, sequence reset (gap fill or reset).
// - All tags and values are ASCII, right-aligned and zero-extended.
// - BodyLength (9) and CheckSum (10) values are sent as 0 placeholders; the serializer fills them.
// PARAMETERS
// - VALUE_WIDTH    `VALUE_DATA_WIDTH       width of val_o and of value inputs
// - COUNTER_DEPTH  80                      width of ASCII sequence-number inputs
// - BEGIN_STRING   56'h4649582E342E33      "FIX.4.3", value of tag 8
// PORTS
// - clk               in   1   clock
// - rst               in   1   asynchronous, active-high reset
// - send_req_i        in   1   send request; accepted when send_req_i && !busy_o
// - type_i            in   4   `logon/`heartbeat/`logout/`resendReq/`gapFill/`reset
// - busy_o            out  1   message in progress; requests ignored
// - msg_seq_num_i     in   COUNTER_DEPTH  tag 34 value (from sequence generator)
// - sender_comp_id_i, target_comp_id_i, sending_time_i  in  VALUE_WIDTH  tags 49/56/52
// - heartbeat_int_i   in   VALUE_WIDTH    tag 108 (logon only)
// - begin_seq_num_i, end_seq_num_i, new_seq_num_i  in  COUNTER_DEPTH  tags 7/16/36
// - ready_i           in   1   serializer accepts the current beat
// - tag_valid_o       out  1   tag beat valid
// - tag_o             out  32  ASCII tag, e.g. 35 -> 32'h00003335
// - val_valid_o       out  1   value beat valid
// - val_o             out  VALUE_WIDTH  ASCII value
// - start_of_message_o out 1   high with the tag-8 beat
// - end_of_message_o  out  1   high with the tag-10 tag beat and its value beat
// - done_o            out  1   1-cycle pulse when the tag-10 value beat is accepted
// - seq_inc_o         out  1   1-cycle pulse coincident with done_o; advances the outgoing seq num
// - error_o           out  1   1-cycle pulse: unsupported type_i; nothing is emitted
// BEHAVIOUR
// - Reset: all outputs 0, state S_IDLE, field index 0. Reset mid-message drops the message; no done_o.
// - Request accept at edge N latches every input. First beat (tag 8) is valid in cycle N+1.
// - States:
//   - S_IDLE -> S_TAG on a valid request.
//   - S_TAG: tag_valid_o=1; on ready_i -> S_VAL.
//   - S_VAL: val_valid_o=1; on ready_i -> S_TAG for the next field, or S_IDLE after tag 10.
// - tag_valid_o and val_valid_o are never high together. A beat holds stable until ready_i.
// - Common field order: 8,9,35,34,49,56,52. Then type-specific fields. Then 10.
// - Type-specific fields:
//   - logon: 98="0", 108.  MsgType 0x41.
//   - heartbeat: none.     MsgType 0x30.
//   - logout: none.        MsgType 0x35.
//   - resendReq: 7, 16.    MsgType 0x32.
//   - gapFill/reset: 123="Y"(0x59)/"N"(0x4E), 36.  MsgType 0x34.
// - busy_o=1 from cycle N+1 until the cycle after done_o. send_req_i while busy is ignored, not queued.
// - Unsupported type_i: error_o pulses at N+1, state stays S_IDLE, busy_o stays 0.
// - ready_i held low indefinitely: outputs freeze. No timeout.
// CONFIGURATION
// - FIX_TX_POSS_DUP_EN defined:
//   - adds inputs poss_dup_i (1) and orig_sending_time_i (VALUE_WIDTH), both latched at accept.
//   - when poss_dup_i=1, after tag 52: 43="Y"(0x59), then 122=orig_sending_time_i.
// - FIX_TX_POSS_DUP_EN undefined: ports absent; tags 43 and 122 are never emitted.
// STRUCTURE
// - fix_tx_pkg: ASCII tag constants, MsgType chars, `resendReq code, field-select enum, state encoding.
// - Sub-module sent_msg_field_table: combinational (type, field index) -> {tag, source select, last}.
// - Top level holds the FSM, input latches, and the value mux.
// TESTING
// - Heartbeat, ready_i=1, seq 8'h35 ("5"): tags 8,9,35,34,49,56,52,10; 35 val 0x30; 34 val 0x35.
//   Exactly one done_o and one seq_inc_o pulse. 16 beats total.
// - Logon, heartbeat_int_i="30"(16'h3330): ... 52,98(0x30),108(0x3330),10.
//   start_of_message_o only on the first beat.
// - gapFill, new_seq_num_i=16'h3130: 123 val 0x59, 36 val 0x3130. Type reset gives 123 val 0x4E.
// - ready_i toggled randomly, 50%: beat contents identical to the ready_i=1 run.
//   Output stable while ready_i=0. send_req_i pulses while busy_o are ignored.
// - type_i=4'hF: error_o pulse. No tag_valid_o/val_valid_o. busy_o stays 0.
// - rst asserted during the tag-49 beat: outputs 0 immediately, no done_o.
//   The next logon request starts again at tag 8.

Source files
------------

// File: rtl/sent_msg_composer_pkg.sv
// Shared constants for the outbound FIX message composer: tag ASCII codes, type codes,
// MsgType characters, the field-select enum and the FSM state encoding.
package sent_msg_composer_pkg;

  localparam int          VALUE_WIDTH_DEF   = 80;
  localparam int          COUNTER_DEPTH_DEF = 80;
  localparam logic [55:0] BEGIN_STRING_DEF  = 56'h4649582E342E33;
  localparam int          IDX_W             = 4;

  // type_i request codes
  localparam logic [3:0] TYPE_LOGON      = 4'h0;
  localparam logic [3:0] TYPE_HEARTBEAT  = 4'h1;
  localparam logic [3:0] TYPE_LOGOUT     = 4'h2;
  localparam logic [3:0] TYPE_RESEND_REQ = 4'h3;
  localparam logic [3:0] TYPE_GAP_FILL   = 4'h4;
  localparam logic [3:0] TYPE_RESET      = 4'h5;

  localparam logic [7:0] MSG_TYPE_LOGON     = 8'h41;
  localparam logic [7:0] MSG_TYPE_HEARTBEAT = 8'h30;
  localparam logic [7:0] MSG_TYPE_LOGOUT    = 8'h35;
  localparam logic [7:0] MSG_TYPE_RESEND    = 8'h32;
  localparam logic [7:0] MSG_TYPE_SEQ_RESET = 8'h34;

  localparam logic [7:0] CHAR_Y    = 8'h59;
  localparam logic [7:0] CHAR_N    = 8'h4E;
  localparam logic [7:0] CHAR_ZERO = 8'h30;

  localparam logic [31:0] TAG_8   = 32'h0000_0038;
  localparam logic [31:0] TAG_9   = 32'h0000_0039;
  localparam logic [31:0] TAG_35  = 32'h0000_3335;
  localparam logic [31:0] TAG_34  = 32'h0000_3334;
  localparam logic [31:0] TAG_49  = 32'h0000_3439;
  localparam logic [31:0] TAG_56  = 32'h0000_3536;
  localparam logic [31:0] TAG_52  = 32'h0000_3532;
  localparam logic [31:0] TAG_43  = 32'h0000_3433;
  localparam logic [31:0] TAG_122 = 32'h0031_3232;
  localparam logic [31:0] TAG_98  = 32'h0000_3938;
  localparam logic [31:0] TAG_108 = 32'h0031_3038;
  localparam logic [31:0] TAG_7   = 32'h0000_0037;
  localparam logic [31:0] TAG_16  = 32'h0000_3136;
  localparam logic [31:0] TAG_123 = 32'h0031_3233;
  localparam logic [31:0] TAG_36  = 32'h0000_3336;
  localparam logic [31:0] TAG_10  = 32'h0000_3130;

  typedef enum logic [3:0] {
    FS_BEGIN,
    FS_ZERO,
    FS_MSG_TYPE,
    FS_SEQ,
    FS_SENDER,
    FS_TARGET,
    FS_TIME,
    FS_CHAR_Y,
    FS_ORIG_TIME,
    FS_CHAR_ZERO,
    FS_HB_INT,
    FS_BEGIN_SEQ,
    FS_END_SEQ,
    FS_GAP_FLAG,
    FS_NEW_SEQ
  } field_sel_e;

  typedef struct packed {
    logic [31:0] tag;
    field_sel_e  sel;
    logic        last;
  } field_entry_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TAG  = 2'd1;
  localparam logic [1:0] S_VAL  = 2'd2;

  function automatic logic type_supported(input logic [3:0] t);
    return (t <= TYPE_RESET);
  endfunction

  function automatic logic [7:0] msg_type_char(input logic [3:0] t);
    logic [7:0] c;
    case (t)
      TYPE_LOGON:                c = MSG_TYPE_LOGON;
      TYPE_HEARTBEAT:            c = MSG_TYPE_HEARTBEAT;
      TYPE_LOGOUT:               c = MSG_TYPE_LOGOUT;
      TYPE_RESEND_REQ:           c = MSG_TYPE_RESEND;
      TYPE_GAP_FILL, TYPE_RESET: c = MSG_TYPE_SEQ_RESET;
      default:                   c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sent_msg_composer_if.sv
// Outbound tag/value beat stream between the composer (master) and the serializer (slave).
interface sent_msg_composer_if
  import sent_msg_composer_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF
);
  logic                   ready_i;
  logic                   tag_valid_o;
  logic [31:0]            tag_o;
  logic                   val_valid_o;
  logic [VALUE_WIDTH-1:0] val_o;
  logic                   start_of_message_o;
  logic                   end_of_message_o;

  modport master (
    input  ready_i,
    output tag_valid_o, tag_o, val_valid_o, val_o, start_of_message_o, end_of_message_o
  );

  modport slave (
    output ready_i,
    input  tag_valid_o, tag_o, val_valid_o, val_o, start_of_message_o, end_of_message_o
  );
endinterface

// File: rtl/sent_msg_composer_field_table.sv
// Combinational message layout: (type, field index, poss-dup) -> {tag, value source, last}.
module sent_msg_field_table
  import sent_msg_composer_pkg::*;
(
  input  logic [3:0]       type_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             poss_dup_i,
  output field_entry_t     entry_o
);

  logic [IDX_W-1:0] opt_base;
  logic [IDX_W-1:0] opt_idx;
  logic [IDX_W-1:0] opt_count;

  // Type-specific fields start after the 7 common fields and any poss-dup pair.
  assign opt_base  = poss_dup_i ? IDX_W'(9) : IDX_W'(7);
  assign opt_idx   = idx_i - opt_base;
  assign opt_count = (type_i == TYPE_HEARTBEAT || type_i == TYPE_LOGOUT) ? IDX_W'(0) : IDX_W'(2);

  always_comb begin
    entry_o = '{tag: TAG_10, sel: FS_ZERO, last: 1'b1};
    if (idx_i < IDX_W'(7)) begin
      entry_o.last = 1'b0;
      case (idx_i[2:0])
        3'd0:    begin entry_o.tag = TAG_8;  entry_o.sel = FS_BEGIN;    end
        3'd1:    begin entry_o.tag = TAG_9;  entry_o.sel = FS_ZERO;     end
        3'd2:    begin entry_o.tag = TAG_35; entry_o.sel = FS_MSG_TYPE; end
        3'd3:    begin entry_o.tag = TAG_34; entry_o.sel = FS_SEQ;      end
        3'd4:    begin entry_o.tag = TAG_49; entry_o.sel = FS_SENDER;   end
        3'd5:    begin entry_o.tag = TAG_56; entry_o.sel = FS_TARGET;   end
        default: begin entry_o.tag = TAG_52; entry_o.sel = FS_TIME;     end
      endcase
    end else if (poss_dup_i && idx_i == IDX_W'(7)) begin
      entry_o = '{tag: TAG_43, sel: FS_CHAR_Y, last: 1'b0};
    end else if (poss_dup_i && idx_i == IDX_W'(8)) begin
      entry_o = '{tag: TAG_122, sel: FS_ORIG_TIME, last: 1'b0};
    end else if (opt_idx < opt_count) begin
      entry_o.last = 1'b0;
      case (type_i)
        TYPE_LOGON: begin
          entry_o.tag = opt_idx[0] ? TAG_108 : TAG_98;
          entry_o.sel = opt_idx[0] ? FS_HB_INT : FS_CHAR_ZERO;
        end
        TYPE_RESEND_REQ: begin
          entry_o.tag = opt_idx[0] ? TAG_16 : TAG_7;
          entry_o.sel = opt_idx[0] ? FS_END_SEQ : FS_BEGIN_SEQ;
        end
        default: begin
          entry_o.tag = opt_idx[0] ? TAG_36 : TAG_123;
          entry_o.sel = opt_idx[0] ? FS_NEW_SEQ : FS_GAP_FLAG;
        end
      endcase
    end
  end

endmodule

// File: rtl/sent_msg_composer.sv
// FIX session message composer: latches a send request and streams its tag/value beats.
// Optional PossDup support (tags 43/122) is enabled by defining FIX_TX_POSS_DUP_EN.
module sent_msg_composer
  import sent_msg_composer_pkg::*;
#(
  parameter int          VALUE_WIDTH   = VALUE_WIDTH_DEF,
  parameter int          COUNTER_DEPTH = COUNTER_DEPTH_DEF,
  parameter logic [55:0] BEGIN_STRING  = BEGIN_STRING_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  sent_msg_composer_if.master      tx,
  input  logic                     send_req_i,
  input  logic [3:0]               type_i,
  output logic                     busy_o,
  input  logic [COUNTER_DEPTH-1:0] msg_seq_num_i,
  input  logic [VALUE_WIDTH-1:0]   sender_comp_id_i,
  input  logic [VALUE_WIDTH-1:0]   target_comp_id_i,
  input  logic [VALUE_WIDTH-1:0]   sending_time_i,
  input  logic [VALUE_WIDTH-1:0]   heartbeat_int_i,
  input  logic [COUNTER_DEPTH-1:0] begin_seq_num_i,
  input  logic [COUNTER_DEPTH-1:0] end_seq_num_i,
  input  logic [COUNTER_DEPTH-1:0] new_seq_num_i,
`ifdef FIX_TX_POSS_DUP_EN
  input  logic                     poss_dup_i,
  input  logic [VALUE_WIDTH-1:0]   orig_sending_time_i,
`endif
  output logic                     done_o,
  output logic                     seq_inc_o,
  output logic                     error_o
);

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     busy_q, busy_d;
  logic [3:0]               type_q, type_d;
  logic [COUNTER_DEPTH-1:0] seq_q, seq_d;
  logic [COUNTER_DEPTH-1:0] bseq_q, bseq_d;
  logic [COUNTER_DEPTH-1:0] eseq_q, eseq_d;
  logic [COUNTER_DEPTH-1:0] nseq_q, nseq_d;
  logic [VALUE_WIDTH-1:0]   sender_q, sender_d;
  logic [VALUE_WIDTH-1:0]   target_q, target_d;
  logic [VALUE_WIDTH-1:0]   time_q, time_d;
  logic [VALUE_WIDTH-1:0]   hb_q, hb_d;
  logic [VALUE_WIDTH-1:0]   orig_time_value;
  logic                     poss_dup_value;
  logic                     req_seen;
  logic                     accept;
  field_entry_t             entry;
  logic [VALUE_WIDTH-1:0]   val_mux;

`ifdef FIX_TX_POSS_DUP_EN
  logic                   poss_dup_q, poss_dup_d;
  logic [VALUE_WIDTH-1:0] orig_time_q, orig_time_d;

  always_comb begin
    poss_dup_d  = accept ? poss_dup_i : poss_dup_q;
    orig_time_d = accept ? orig_sending_time_i : orig_time_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poss_dup_q  <= 1'b0;
      orig_time_q <= '0;
    end else begin
      poss_dup_q  <= poss_dup_d;
      orig_time_q <= orig_time_d;
    end
  end

  assign poss_dup_value  = poss_dup_q;
  assign orig_time_value = orig_time_q;
`else
  assign poss_dup_value  = 1'b0;
  assign orig_time_value = '0;
`endif

  assign req_seen = send_req_i && !busy_q && (state_q == S_IDLE);
  assign accept   = req_seen && type_supported(type_i);

  sent_msg_field_table u_field_table (
    .type_i     (type_q),
    .idx_i      (idx_q),
    .poss_dup_i (poss_dup_value),
    .entry_o    (entry)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_seen) begin
          if (accept) begin
            state_d = S_TAG;
            idx_d   = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_TAG: if (tx.ready_i) state_d = S_VAL;
      S_VAL: begin
        if (tx.ready_i) begin
          if (entry.last) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_TAG;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    // busy spans the done cycle so a request arriving with done_o is dropped
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_comb begin
    type_d   = accept ? type_i           : type_q;
    seq_d    = accept ? msg_seq_num_i    : seq_q;
    bseq_d   = accept ? begin_seq_num_i  : bseq_q;
    eseq_d   = accept ? end_seq_num_i    : eseq_q;
    nseq_d   = accept ? new_seq_num_i    : nseq_q;
    sender_d = accept ? sender_comp_id_i : sender_q;
    target_d = accept ? target_comp_id_i : target_q;
    time_d   = accept ? sending_time_i   : time_q;
    hb_d     = accept ? heartbeat_int_i  : hb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      type_q   <= '0;
      seq_q    <= '0;
      bseq_q   <= '0;
      eseq_q   <= '0;
      nseq_q   <= '0;
      sender_q <= '0;
      target_q <= '0;
      time_q   <= '0;
      hb_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      type_q   <= type_d;
      seq_q    <= seq_d;
      bseq_q   <= bseq_d;
      eseq_q   <= eseq_d;
      nseq_q   <= nseq_d;
      sender_q <= sender_d;
      target_q <= target_d;
      time_q   <= time_d;
      hb_q     <= hb_d;
    end
  end

  always_comb begin
    val_mux = '0;
    case (entry.sel)
      FS_BEGIN:     val_mux = VALUE_WIDTH'(BEGIN_STRING);
      FS_MSG_TYPE:  val_mux = VALUE_WIDTH'(msg_type_char(type_q));
      FS_SEQ:       val_mux = VALUE_WIDTH'(seq_q);
      FS_SENDER:    val_mux = sender_q;
      FS_TARGET:    val_mux = target_q;
      FS_TIME:      val_mux = time_q;
      FS_CHAR_Y:    val_mux = VALUE_WIDTH'(CHAR_Y);
      FS_ORIG_TIME: val_mux = orig_time_value;
      FS_CHAR_ZERO: val_mux = VALUE_WIDTH'(CHAR_ZERO);
      FS_HB_INT:    val_mux = hb_q;
      FS_BEGIN_SEQ: val_mux = VALUE_WIDTH'(bseq_q);
      FS_END_SEQ:   val_mux = VALUE_WIDTH'(eseq_q);
      FS_GAP_FLAG:  val_mux = VALUE_WIDTH'((type_q == TYPE_GAP_FILL) ? CHAR_Y : CHAR_N);
      FS_NEW_SEQ:   val_mux = VALUE_WIDTH'(nseq_q);
      default:      val_mux = '0;
    endcase
  end

  // Tag/value buses are forced to zero outside their beats so idle and reset read as all-0.
  assign tx.tag_valid_o        = (state_q == S_TAG);
  assign tx.val_valid_o        = (state_q == S_VAL);
  assign tx.tag_o              = (state_q == S_TAG) ? entry.tag : 32'h0;
  assign tx.val_o              = (state_q == S_VAL) ? val_mux : '0;
  assign tx.start_of_message_o = (state_q == S_TAG) && (idx_q == '0);
  assign tx.end_of_message_o   = (state_q != S_IDLE) && entry.last;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign seq_inc_o = done_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_sent_msg_composer.sv
// Directed self-checking bench for sent_msg_composer: one line per accepted beat or check failure.
module tb_sent_msg_composer;

  localparam logic [3:0] T_LOGON  = 4'h0;
  localparam logic [3:0] T_HB     = 4'h1;
  localparam logic [3:0] T_LOGOUT = 4'h2;
  localparam logic [3:0] T_RESEND = 4'h3;
  localparam logic [3:0] T_GAP    = 4'h4;
  localparam logic [3:0] T_RESET  = 4'h5;

  localparam logic [79:0] V_BEGIN  = 80'h4649582E342E33;
  localparam logic [79:0] V_SEQ    = 80'h35;
  localparam logic [79:0] V_SENDER = 80'h53454E44;
  localparam logic [79:0] V_TARGET = 80'h54475430;
  localparam logic [79:0] V_TIME   = 80'h3132333435;
  localparam logic [79:0] V_HB     = 80'h3330;
  localparam logic [79:0] V_BSEQ   = 80'h31;
  localparam logic [79:0] V_ESEQ   = 80'h39;
  localparam logic [79:0] V_NSEQ   = 80'h3130;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req_i = 1'b0;
  logic [3:0]  type_i = 4'h0;
  logic        busy_o, done_o, seq_inc_o, error_o;
  logic [79:0] msg_seq_num_i, begin_seq_num_i, end_seq_num_i, new_seq_num_i;
  logic [79:0] sender_comp_id_i, target_comp_id_i, sending_time_i, heartbeat_int_i;
`ifdef FIX_TX_POSS_DUP_EN
  logic        poss_dup_i = 1'b0;
  logic [79:0] orig_sending_time_i = '0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_tag[16];
  logic [79:0] exp_val[16];
  int          n_exp;

  sent_msg_composer_if #(.VALUE_WIDTH(80)) tx_if ();

  sent_msg_composer #(.VALUE_WIDTH(80), .COUNTER_DEPTH(80)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tx                  (tx_if.master),
    .send_req_i          (send_req_i),
    .type_i              (type_i),
    .busy_o              (busy_o),
    .msg_seq_num_i       (msg_seq_num_i),
    .sender_comp_id_i    (sender_comp_id_i),
    .target_comp_id_i    (target_comp_id_i),
    .sending_time_i      (sending_time_i),
    .heartbeat_int_i     (heartbeat_int_i),
    .begin_seq_num_i     (begin_seq_num_i),
    .end_seq_num_i       (end_seq_num_i),
    .new_seq_num_i       (new_seq_num_i),
`ifdef FIX_TX_POSS_DUP_EN
    .poss_dup_i          (poss_dup_i),
    .orig_sending_time_i (orig_sending_time_i),
`endif
    .done_o              (done_o),
    .seq_inc_o           (seq_inc_o),
    .error_o             (error_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic load_inputs(input bit scramble);
    msg_seq_num_i    = scramble ? ~V_SEQ    : V_SEQ;
    sender_comp_id_i = scramble ? ~V_SENDER : V_SENDER;
    target_comp_id_i = scramble ? ~V_TARGET : V_TARGET;
    sending_time_i   = scramble ? ~V_TIME   : V_TIME;
    heartbeat_int_i  = scramble ? ~V_HB     : V_HB;
    begin_seq_num_i  = scramble ? ~V_BSEQ   : V_BSEQ;
    end_seq_num_i    = scramble ? ~V_ESEQ   : V_ESEQ;
    new_seq_num_i    = scramble ? ~V_NSEQ   : V_NSEQ;
    type_i           = scramble ? 4'hE : type_i;
  endtask

  task automatic add(input logic [31:0] t, input logic [79:0] v);
    exp_tag[n_exp] = t;
    exp_val[n_exp] = v;
    n_exp++;
  endtask

  task automatic expect_common(input logic [79:0] msg_type);
    n_exp = 0;
    add(32'h38, V_BEGIN);
    add(32'h39, 80'h0);
    add(32'h3335, msg_type);
    add(32'h3334, V_SEQ);
    add(32'h3439, V_SENDER);
    add(32'h3536, V_TARGET);
    add(32'h3532, V_TIME);
  endtask

  // Sends one request and follows the beat stream against exp_tag/exp_val.
  task automatic run_msg(input string name, input logic [3:0] typ, input bit rand_ready, input bit poke);
    int fld, tacc, vacc, dones;
    bit finished, held, rdy;
    logic ptv, pvv;
    logic [31:0] ptag;
    logic [79:0] pval;
    fld = 0; tacc = 0; vacc = 0; dones = 0; finished = 0; held = 0;
    ptv = 0; pvv = 0; ptag = '0; pval = '0;
    type_i = typ;
    load_inputs(1'b0);
    send_req_i = 1'b1;
    tx_if.ready_i = 1'b1;
    tick();
    send_req_i = 1'b0;
    load_inputs(1'b1);
    chk({name, " busy_first"}, busy_o, 1'b1);
    chk({name, " first_tag_valid"}, tx_if.tag_valid_o, 1'b1);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      chk({name, " valid_excl"}, tx_if.tag_valid_o & tx_if.val_valid_o, 1'b0);
      chk({name, " seq_inc"}, seq_inc_o, done_o);
      if (held) begin
        chk({name, " hold_ctl"}, {tx_if.tag_valid_o, tx_if.val_valid_o}, {ptv, pvv});
        chk({name, " hold_tag"}, tx_if.tag_o, ptag);
        chk({name, " hold_val"}, tx_if.val_o, pval);
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_if.ready_i = rdy;
      send_req_i = poke && (tx_if.tag_valid_o || tx_if.val_valid_o || done_o) ? 1'b1 : 1'b0;
      if (done_o) begin
        dones++;
        finished = 1;
        chk({name, " done_after_all"}, fld, n_exp);
      end
      if (tx_if.tag_valid_o && rdy) begin
        $display("%s beat %0d: tag %0h", name, tacc + vacc, tx_if.tag_o);
        chk({name, " tag"}, tx_if.tag_o, fld < n_exp ? exp_tag[fld] : 32'hFFFF_FFFF);
        chk({name, " som"}, tx_if.start_of_message_o, fld == 0);
        chk({name, " eom_tag"}, tx_if.end_of_message_o, fld == n_exp - 1);
        tacc++;
      end
      if (tx_if.val_valid_o && rdy) begin
        $display("%s beat %0d: val %0h", name, tacc + vacc, tx_if.val_o);
        chk({name, " val"}, tx_if.val_o, fld < n_exp ? exp_val[fld] : 80'hFFFF);
        chk({name, " som_val"}, tx_if.start_of_message_o, 1'b0);
        chk({name, " eom_val"}, tx_if.end_of_message_o, fld == n_exp - 1);
        vacc++;
        fld++;
      end
      held = (tx_if.tag_valid_o || tx_if.val_valid_o) && !rdy;
      ptv = tx_if.tag_valid_o; pvv = tx_if.val_valid_o;
      ptag = tx_if.tag_o; pval = tx_if.val_o;
      tick();
    end
    send_req_i = 1'b0;
    tx_if.ready_i = 1'b1;
    chk({name, " done_count"}, dones, 1);
    chk({name, " tag_beats"}, tacc, n_exp);
    chk({name, " val_beats"}, vacc, n_exp);
    chk({name, " busy_after"}, busy_o, 1'b0);
    chk({name, " done_single"}, done_o, 1'b0);
    chk({name, " no_restart"}, tx_if.tag_valid_o, 1'b0);
    load_inputs(1'b0);
  endtask

  initial begin : stim
    bit found;
    tx_if.ready_i = 1'b1;
    load_inputs(1'b0);
    tick(); tick();
    chk("reset tag_valid", tx_if.tag_valid_o, 1'b0);
    chk("reset val_valid", tx_if.val_valid_o, 1'b0);
    chk("reset tag", tx_if.tag_o, 32'h0);
    chk("reset val", tx_if.val_o, 80'h0);
    chk("reset flags", {busy_o, done_o, seq_inc_o, error_o,
                        tx_if.start_of_message_o, tx_if.end_of_message_o}, 6'b0);
    rst = 1'b0;
    tick();

    expect_common(80'h30); add(32'h3130, 80'h0);
    run_msg("heartbeat", T_HB, 1'b0, 1'b0);

    expect_common(80'h41); add(32'h3938, 80'h30); add(32'h313038, V_HB); add(32'h3130, 80'h0);
    run_msg("logon", T_LOGON, 1'b0, 1'b0);

    expect_common(80'h34); add(32'h313233, 80'h59); add(32'h3336, V_NSEQ); add(32'h3130, 80'h0);
    run_msg("gapfill", T_GAP, 1'b0, 1'b0);

    expect_common(80'h34); add(32'h313233, 80'h4E); add(32'h3336, V_NSEQ); add(32'h3130, 80'h0);
    run_msg("seqreset", T_RESET, 1'b0, 1'b0);

    expect_common(80'h32); add(32'h37, V_BSEQ); add(32'h3136, V_ESEQ); add(32'h3130, 80'h0);
    run_msg("resend", T_RESEND, 1'b0, 1'b0);

    expect_common(80'h35); add(32'h3130, 80'h0);
    run_msg("logout", T_LOGOUT, 1'b0, 1'b0);

    expect_common(80'h41); add(32'h3938, 80'h30); add(32'h313038, V_HB); add(32'h3130, 80'h0);
    run_msg("logon_rand", T_LOGON, 1'b1, 1'b1);

    expect_common(80'h30); add(32'h3130, 80'h0);
    run_msg("heartbeat_rand", T_HB, 1'b1, 1'b1);

    // Unsupported type
    type_i = 4'hF;
    send_req_i = 1'b1;
    tick();
    send_req_i = 1'b0;
    $display("bad type: error_o %0b busy_o %0b", error_o, busy_o);
    chk("badtype error", error_o, 1'b1);
    chk("badtype valid", {tx_if.tag_valid_o, tx_if.val_valid_o}, 2'b00);
    chk("badtype busy", busy_o, 1'b0);
    tick();
    chk("badtype error_pulse", error_o, 1'b0);
    chk("badtype still_idle", {tx_if.tag_valid_o, tx_if.val_valid_o, busy_o}, 3'b000);

    // Reset in the middle of the tag-49 beat
    type_i = T_LOGON;
    load_inputs(1'b0);
    tx_if.ready_i = 1'b1;
    send_req_i = 1'b1;
    tick();
    send_req_i = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (tx_if.tag_valid_o && tx_if.tag_o == 32'h3439) found = 1;
      else tick();
    end
    chk("midreset reach_49", found, 1'b1);
    rst = 1'b1;
    #1;
    $display("mid-message reset: tag_valid %0b busy %0b", tx_if.tag_valid_o, busy_o);
    chk("midreset outputs", {tx_if.tag_valid_o, tx_if.val_valid_o, busy_o, done_o,
                             tx_if.start_of_message_o, tx_if.end_of_message_o}, 6'b0);
    chk("midreset tag", tx_if.tag_o, 32'h0);
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midreset no_done", {done_o, seq_inc_o, tx_if.tag_valid_o}, 3'b000);
    end

    expect_common(80'h41); add(32'h3938, 80'h30); add(32'h313038, V_HB); add(32'h3130, 80'h0);
    run_msg("logon_after_reset", T_LOGON, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
